// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and next-state function for the 4-bit LFSR
//
// Purpose: width, default seed, feedback tap positions and the next-state
//          function used by the lfsr block and by anything that needs to
//          predict its sequence.
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b1000;

    // Feedback taps. This pair is not maximal-length: from the default seed
    // the register walks a 6-state cycle, and 0000 maps onto itself.
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - free-running 4-bit Fibonacci LFSR pattern source
//
// Purpose: advances one state per clock while reset is high and loads SEED on
//          every rising edge that samples reset low.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-low reset, loads SEED
//   lfsr_o - current register state, driven straight from the flops
module lfsr
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] q;

    // No escape from 0000 is provided; a legal nonzero SEED never reaches it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

    assign lfsr_o = q;

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - directed and model-based bench for lfsr
module tb_lfsr;
    import lfsr_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] lfsr_o;

    int compared   = 0;
    int mismatched = 0;

    lfsr #(.SEED(4'b1000)) dut (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq [6];
        logic [3:0] prev;
        logic [3:0] exp;
        int         cnt [16];
        int         rlen;
        int         flen;

        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0101;
        seq[3] = 4'b1010; seq[4] = 4'b0100; seq[5] = 4'b1000;

        // Reset hold for three edges.
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold_%0d", i), lfsr_o, 4'b1000);
        end

        // Free run: documented sequence, then the N=6/9/13 points.
        reset = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            step();
            check($sformatf("free_run_n%0d", n), lfsr_o, seq[(n - 1) % 6]);
        end
        check("free_run_n13_0001", lfsr_o, 4'b0001);

        // Period check: 60 more cycles from 0001 visit each state exactly 10 times.
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int i = 0; i < 60; i++) begin
            prev = lfsr_o;
            step();
            check("period_model", lfsr_o, lfsr_next(prev));
            cnt[lfsr_o]++;
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("period_count_%b", seq[i]), 4'(cnt[seq[i]]), 4'd10);
        check("period_count_0000", 4'(cnt[0]), 4'd0);

        // Mid-sequence reset: reload from 1000 after 4 edges.
        reset = 1'b0;
        step();
        check("mid_pre_reset", lfsr_o, 4'b1000);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("mid_at_1010", lfsr_o, 4'b1010);
        reset = 1'b0;
        step();
        check("mid_reload", lfsr_o, 4'b1000);
        reset = 1'b1;
        step();
        check("mid_restart", lfsr_o, 4'b0001);
        step();
        check("mid_restart_2", lfsr_o, 4'b0010);

        // Reset pulse between edges must not reload anything.
        #2 reset = 1'b0;
        #1 check("sync_glitch_hold", lfsr_o, 4'b0010);
        #1 reset = 1'b1;
        step();
        check("sync_glitch_next", lfsr_o, 4'b0101);

        // Random reset/run intervals checked against the package model.
        exp = lfsr_o;
        for (int k = 0; k < 100; k++) begin
            rlen = $urandom_range(0, 2);
            flen = $urandom_range(1, 8);
            reset = 1'b0;
            for (int i = 0; i < rlen; i++) begin
                step();
                exp = 4'b1000;
                check("rand_reset", lfsr_o, exp);
            end
            reset = 1'b1;
            for (int i = 0; i < flen; i++) begin
                step();
                exp = lfsr_next(exp);
                check("rand_run", lfsr_o, exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
